// File: rtl/bdl_seq.sv
// bdl_seq: fetches a buffer descriptor from host memory into the BDL register file over the
// Q-bus DMA master and writes status words back. Define BDL_CHAIN_EN to follow chained descriptors.
module bdl_seq #(
  parameter logic [15:0] FLAG_USE = 16'hC000,
  parameter int unsigned TMO      = 255,
  parameter int unsigned MAXCHAIN = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n,
  input  logic        cmd_fetch_i,
  input  logic        cmd_stat_i,
  input  logic [21:0] base_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        valid_o,
  output logic [1:0]  err_o,
  output logic [21:0] desc_adr_o,
  output logic        dma_req_o,
  output logic        dma_we_o,
  output logic [21:0] dma_adr_o,
  output logic [15:0] dma_dat_o,
  input  logic [15:0] dma_dat_i,
  input  logic        dma_ack_i,
  output logic        bdl_stb_o,
  output logic        bdl_we_o,
  output logic [2:0]  bdl_adr_o,
  output logic [15:0] bdl_dat_o,
  input  logic [15:0] bdl_dat_i
);

  typedef enum logic [3:0] {
    StIdle, StFlag, StRd1, StRd2, StRd3, StCheck, StSrd4, StSwr4, StSrd5, StSwr5, StFin
  } state_e;

  state_e state_q, state_d;

  logic        req_q, we_q;
  logic [21:0] adr_q;
  logic [15:0] dat_q;
  logic [7:0]  tmo_q;
  logic        ph_q;
  logic        v_q, c_q;
  logic [15:0] sdat_q;
  logic [21:0] desc_q;
  logic [1:0]  err_q;
  logic        valid_q;
  logic        bdl_stb_q, bdl_we_q;
  logic [2:0]  bdl_adr_q;
  logic [15:0] bdl_dat_q;

  logic        dma_state, issue, acked, tmo_hit, srd, start_fetch, start_stat;
  logic        issue_we;
  logic [21:0] issue_adr;
  logic [15:0] issue_dat;
  logic        chain_go;
  logic [21:0] chain_adr;
  logic [1:0]  chain_err;

  assign dma_state   = state_q inside {StFlag, StRd1, StRd2, StRd3, StSwr4, StSwr5};
  assign srd         = state_q inside {StSrd4, StSrd5};
  // A request is issued on the first cycle of each DMA state; req_q is always low on entry.
  assign issue       = dma_state & ~req_q;
  assign acked       = req_q & dma_ack_i;
  assign tmo_hit     = req_q & ~dma_ack_i & (tmo_q == 8'd1);
  assign start_fetch = (state_q == StIdle) & cmd_fetch_i;
  assign start_stat  = (state_q == StIdle) & ~cmd_fetch_i & cmd_stat_i;

`ifdef BDL_CHAIN_EN
  localparam int unsigned CntW = $clog2(MAXCHAIN + 1);

  logic [CntW-1:0] hops_q;
  logic [5:0]      nxt_hi_q;
  logic [14:0]     nxt_lo_q;

  assign chain_go  = v_q & c_q & (hops_q != CntW'(MAXCHAIN));
  assign chain_adr = {nxt_hi_q, nxt_lo_q, 1'b0};
  assign chain_err = 2'b10;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      hops_q   <= '0;
      nxt_hi_q <= '0;
      nxt_lo_q <= '0;
    end else begin
      if (start_fetch) begin
        hops_q <= '0;
      end else if ((state_q == StCheck) && chain_go) begin
        hops_q <= hops_q + 1'b1;
      end
      if (acked && (state_q == StRd1)) nxt_hi_q <= dma_dat_i[5:0];
      if (acked && (state_q == StRd2)) nxt_lo_q <= dma_dat_i[15:1];
    end
  end
`else
  logic unused_maxchain;

  assign chain_go        = 1'b0;
  assign chain_adr       = desc_q;
  assign chain_err       = 2'b11;
  assign unused_maxchain = |MAXCHAIN;
`endif

  // State register
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_fetch_i) begin
          state_d = StFlag;
        end else if (cmd_stat_i) begin
          state_d = StSrd4;
        end
      end
      StFlag:  if (acked) state_d = StRd1;   else if (tmo_hit) state_d = StFin;
      StRd1:   if (acked) state_d = StRd2;   else if (tmo_hit) state_d = StFin;
      StRd2:   if (acked) state_d = StRd3;   else if (tmo_hit) state_d = StFin;
      StRd3:   if (acked) state_d = StCheck; else if (tmo_hit) state_d = StFin;
      StCheck: state_d = chain_go ? StFlag : StFin;
      StSrd4:  if (ph_q) state_d = StSwr4;
      StSwr4:  if (acked) state_d = StSrd5;  else if (tmo_hit) state_d = StFin;
      StSrd5:  if (ph_q) state_d = StSwr5;
      StSwr5:  if (acked || tmo_hit) state_d = StFin;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy_o = (state_q != StIdle);
    done_o = (state_q == StFin);
  end

  // Host transfer parameters for the request issued in the current state
  always_comb begin
    issue_we  = 1'b0;
    issue_adr = desc_q;
    issue_dat = 16'h0000;
    unique case (state_q)
      StFlag: begin
        issue_we  = 1'b1;
        issue_dat = FLAG_USE;
      end
      StRd1:  issue_adr = desc_q + 22'd2;
      StRd2:  issue_adr = desc_q + 22'd4;
      StRd3:  issue_adr = desc_q + 22'd6;
      StSwr4: begin
        issue_we  = 1'b1;
        issue_adr = desc_q + 22'd8;
        issue_dat = sdat_q;
      end
      StSwr5: begin
        issue_we  = 1'b1;
        issue_adr = desc_q + 22'd10;
        issue_dat = sdat_q;
      end
      default: ;
    endcase
  end

  // DMA channel and timeout
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      req_q <= 1'b0;
      we_q  <= 1'b0;
      adr_q <= '0;
      dat_q <= '0;
      tmo_q <= '0;
    end else if (issue) begin
      req_q <= 1'b1;
      we_q  <= issue_we;
      adr_q <= issue_adr;
      dat_q <= issue_dat;
      tmo_q <= 8'(TMO);
    end else if (acked || tmo_hit) begin
      req_q <= 1'b0;
    end else if (req_q) begin
      tmo_q <= tmo_q - 8'd1;
    end
  end

  // BDL port: writes are strobed on the cycle after the DMA ack
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      bdl_stb_q <= 1'b0;
      bdl_we_q  <= 1'b0;
      bdl_adr_q <= '0;
      bdl_dat_q <= '0;
      ph_q      <= 1'b0;
      sdat_q    <= '0;
    end else begin
      bdl_stb_q <= 1'b0;
      bdl_we_q  <= 1'b0;
      ph_q      <= srd & ~ph_q;
      if (start_stat) bdl_adr_q <= 3'd4;
      if (srd && ph_q) sdat_q <= bdl_dat_i;
      if (acked) begin
        unique case (state_q)
          StFlag: begin
            bdl_stb_q <= 1'b1;
            bdl_we_q  <= 1'b1;
            bdl_adr_q <= 3'd0;
            bdl_dat_q <= FLAG_USE;
          end
          StRd1, StRd2, StRd3: begin
            bdl_stb_q <= 1'b1;
            bdl_we_q  <= 1'b1;
            bdl_adr_q <= (state_q == StRd1) ? 3'd1 : (state_q == StRd2) ? 3'd2 : 3'd3;
            bdl_dat_q <= dma_dat_i;
          end
          StSwr4:  bdl_adr_q <= 3'd5;
          default: ;
        endcase
      end
    end
  end

  // Descriptor bookkeeping and result flags
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      desc_q  <= '0;
      v_q     <= 1'b0;
      c_q     <= 1'b0;
      err_q   <= 2'b00;
      valid_q <= 1'b0;
    end else begin
      if (start_fetch) desc_q <= base_i & 22'h3FFFFE;
      if (start_fetch || start_stat) begin
        err_q   <= 2'b00;
        valid_q <= 1'b0;
      end
      if (acked && (state_q == StRd1)) begin
        v_q <= dma_dat_i[15];
        c_q <= dma_dat_i[14];
      end
      if (tmo_hit) begin
        err_q   <= 2'b01;
        valid_q <= 1'b0;
      end
      if (state_q == StCheck) begin
        if (!v_q) begin
          valid_q <= 1'b0;
        end else if (!c_q) begin
          valid_q <= 1'b1;
        end else if (chain_go) begin
          desc_q <= chain_adr;
        end else begin
          err_q   <= chain_err;
          valid_q <= 1'b0;
        end
      end
    end
  end

  assign valid_o    = valid_q;
  assign err_o      = err_q;
  assign desc_adr_o = desc_q;
  assign dma_req_o  = req_q;
  assign dma_we_o   = we_q;
  assign dma_adr_o  = adr_q;
  assign dma_dat_o  = dat_q;
  assign bdl_stb_o  = bdl_stb_q;
  assign bdl_we_o   = bdl_we_q;
  assign bdl_adr_o  = bdl_adr_q;
  assign bdl_dat_o  = bdl_dat_q;

endmodule

// File: tb/tb_bdl_seq.sv
// tb_bdl_seq: table-driven fetch vectors plus hand-written stat, collision, timeout and reset
// sequences; host memory, DMA responder and BDL register file are modelled in the bench.
module tb_bdl_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_fetch, cmd_stat;
  logic [21:0] base;
  logic        busy, done, valid;
  logic [1:0]  err;
  logic [21:0] desc_adr;
  logic        dma_req, dma_we;
  logic [21:0] dma_adr;
  logic [15:0] dma_dat_o, dma_dat_i;
  logic        dma_ack;
  logic        bdl_stb, bdl_we;
  logic [2:0]  bdl_adr;
  logic [15:0] bdl_dat_o, bdl_dat_i;

  always #5 clk = ~clk;

  bdl_seq dut (
    .wb_clk_i    (clk),
    .wb_rst_n    (rst_n),
    .cmd_fetch_i (cmd_fetch),
    .cmd_stat_i  (cmd_stat),
    .base_i      (base),
    .busy_o      (busy),
    .done_o      (done),
    .valid_o     (valid),
    .err_o       (err),
    .desc_adr_o  (desc_adr),
    .dma_req_o   (dma_req),
    .dma_we_o    (dma_we),
    .dma_adr_o   (dma_adr),
    .dma_dat_o   (dma_dat_o),
    .dma_dat_i   (dma_dat_i),
    .dma_ack_i   (dma_ack),
    .bdl_stb_o   (bdl_stb),
    .bdl_we_o    (bdl_we),
    .bdl_adr_o   (bdl_adr),
    .bdl_dat_o   (bdl_dat_o),
    .bdl_dat_i   (bdl_dat_i)
  );

  typedef struct packed {
    logic [21:0] adr;
    logic [15:0] dat;
  } wr_t;

  typedef struct packed {
    logic [21:0] base;
    logic [15:0] w1, w2, w3;
    logic        is_chain;
    logic        exp_valid;
    logic [1:0]  exp_err;
    logic [21:0] exp_desc;
  } vec_t;

  int n_chk = 0;
  int n_err = 0;

  wr_t         exp_host[$];
  wr_t         exp_bdl[$];
  logic [15:0] host_mem[logic [21:0]];
  logic [15:0] bdl_regs[8];
  logic [15:0] preset4, preset5;
  int          lat_cfg = 1;
  logic        ack_en = 1'b1;
  int          ack_cnt = 0;

  assign bdl_dat_i = (bdl_adr == 3'd4) ? preset4 : (bdl_adr == 3'd5) ? preset5 : bdl_regs[bdl_adr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic fail_unexp(input string name, input logic [21:0] a, input logic [15:0] d);
    n_chk++;
    n_err++;
    $display("FAIL %s: got transfer adr %h dat %h, required none", name, a, d);
  endtask

  function automatic logic [15:0] rd_host(input logic [21:0] a);
    return host_mem.exists(a) ? host_mem[a] : 16'h0000;
  endfunction

  // DMA responder and BDL register-file model, sampled on the falling edge
  initial begin
    wr_t         w;
    logic        p_req = 1'b0;
    logic        p_we = 1'b0;
    logic [21:0] p_adr = '0;
    logic [15:0] p_dat = '0;
    int          lat = 0;
    dma_ack   = 1'b0;
    dma_dat_i = 16'h0;
    for (int i = 0; i < 8; i++) bdl_regs[i] = 16'h0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        dma_ack = 1'b0;
        lat     = 0;
        p_req   = 1'b0;
        continue;
      end
      if (bdl_stb) begin
        chk("bdl_stb_busy", {31'd0, busy}, 32'd1);
        if (bdl_we) begin
          bdl_regs[bdl_adr] = bdl_dat_o;
          if (exp_bdl.size() == 0) begin
            fail_unexp("bdl_write", {19'd0, bdl_adr}, bdl_dat_o);
          end else begin
            w = exp_bdl.pop_front();
            chk("bdl_adr", {29'd0, bdl_adr}, {29'd0, w.adr[2:0]});
            chk("bdl_dat", {16'd0, bdl_dat_o}, {16'd0, w.dat});
          end
        end
      end
      if (p_req && dma_req)
        chk("dma_stable", {dma_we, dma_adr, dma_dat_o[8:0]} ^ {p_we, p_adr, p_dat[8:0]}, 32'd0);
      if (p_req && dma_req) chk("dma_dat_stable", {16'd0, dma_dat_o}, {16'd0, p_dat});
      p_req = dma_req;
      p_we  = dma_we;
      p_adr = dma_adr;
      p_dat = dma_dat_o;
      if (dma_ack) begin
        dma_ack = 1'b0;
        chk("req_drop_after_ack", {31'd0, dma_req}, 32'd0);
      end else if (dma_req && ack_en) begin
        lat++;
        if (lat >= lat_cfg) begin
          lat = 0;
          ack_cnt++;
          chk("dma_adr_even", {31'd0, dma_adr[0]}, 32'd0);
          if (dma_we) begin
            if (exp_host.size() == 0) begin
              fail_unexp("host_write", dma_adr, dma_dat_o);
            end else begin
              w = exp_host.pop_front();
              chk("host_wr_adr", {10'd0, dma_adr}, {10'd0, w.adr});
              chk("host_wr_dat", {16'd0, dma_dat_o}, {16'd0, w.dat});
            end
            host_mem[dma_adr] = dma_dat_o;
          end else begin
            dma_dat_i = rd_host(dma_adr);
          end
          dma_ack = 1'b1;
        end
      end
    end
  end

  task automatic load_desc(input logic [21:0] a, input logic [15:0] w1, w2, w3);
    logic [21:0] b;
    b = a & 22'h3FFFFE;
    host_mem[b + 22'd2] = w1;
    host_mem[b + 22'd4] = w2;
    host_mem[b + 22'd6] = w3;
  endtask

  task automatic push_fetch(input logic [21:0] a, input logic [15:0] w1, w2, w3);
    exp_host.push_back({a & 22'h3FFFFE, 16'hC000});
    exp_bdl.push_back({22'd0, 16'hC000});
    exp_bdl.push_back({22'd1, w1});
    exp_bdl.push_back({22'd2, w2});
    exp_bdl.push_back({22'd3, w3});
  endtask

  task automatic pulse(input logic f, input logic s, input logic [21:0] b);
    cmd_fetch = f;
    cmd_stat  = s;
    base      = b;
    @(negedge clk);
    cmd_fetch = 1'b0;
    cmd_stat  = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      #1;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk(name, {31'd0, seen}, 32'd1);
  endtask

  task automatic chk_queues(input string name);
    chk({name, "_host_q"}, exp_host.size(), 32'd0);
    chk({name, "_bdl_q"}, exp_bdl.size(), 32'd0);
  endtask

  vec_t vecs[5];

  initial begin
    int a0;
    int n;
    vecs[0] = '{22'h001000, 16'h8000, 16'h2000, 16'hFF00, 1'b0, 1'b1, 2'b00, 22'h001000};
    vecs[1] = '{22'h002001, 16'h0000, 16'h1111, 16'h2222, 1'b0, 1'b0, 2'b00, 22'h002000};
    vecs[2] = '{22'h3FFFFA, 16'h8ABC, 16'h0000, 16'h5A5A, 1'b0, 1'b1, 2'b00, 22'h3FFFFA};
    vecs[3] = '{22'h010000, 16'hBF3F, 16'h1234, 16'h4321, 1'b0, 1'b1, 2'b00, 22'h010000};
    vecs[4] = '{22'h001000, 16'hC003, 16'h4000, 16'h0000, 1'b1, 1'b0, 2'b11, 22'h001000};

    rst_n     = 1'b0;
    cmd_fetch = 1'b0;
    cmd_stat  = 1'b0;
    base      = '0;
    preset4   = 16'h0;
    preset5   = 16'h0;
    #1;
    chk("reset_busy_done_req", {29'd0, busy, done, dma_req}, 32'd0);
    chk("reset_err_valid_stb", {28'd0, err, valid, bdl_stb}, 32'd0);
    chk("reset_desc", {10'd0, desc_adr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
`ifdef BDL_CHAIN_EN
      if (vecs[i].is_chain) continue;
`endif
      lat_cfg = 1 + (i % 3);
      load_desc(vecs[i].base, vecs[i].w1, vecs[i].w2, vecs[i].w3);
      push_fetch(vecs[i].base, vecs[i].w1, vecs[i].w2, vecs[i].w3);
      a0 = ack_cnt;
      pulse(1'b1, 1'b0, vecs[i].base);
      wait_done("fetch_done", 300);
      chk("fetch_dma_cycles", ack_cnt - a0, 32'd4);
      chk("fetch_valid", {31'd0, valid}, {31'd0, vecs[i].exp_valid});
      chk("fetch_err", {30'd0, err}, {30'd0, vecs[i].exp_err});
      chk("fetch_desc", {10'd0, desc_adr}, {10'd0, vecs[i].exp_desc});
      chk("host_flag", {16'd0, rd_host(vecs[i].base & 22'h3FFFFE)}, 32'h0000C000);
      chk("bdl_reg0", {16'd0, bdl_regs[0]}, 32'h0000C000);
      chk("bdl_reg1", {16'd0, bdl_regs[1]}, {16'd0, vecs[i].w1});
      chk("bdl_reg3", {16'd0, bdl_regs[3]}, {16'd0, vecs[i].w3});
      chk_queues("fetch");
      @(negedge clk);
      #1;
      chk("fetch_idle", {31'd0, busy}, 32'd0);
    end

`ifdef BDL_CHAIN_EN
    // Descriptor at 034000 points to itself, so every hop is chained until the limit.
    lat_cfg = 1;
    load_desc(22'h001000, 16'hC003, 16'h4000, 16'h0000);
    load_desc(22'h034000, 16'hC003, 16'h4000, 16'h0000);
    push_fetch(22'h001000, 16'hC003, 16'h4000, 16'h0000);
    repeat (4) push_fetch(22'h034000, 16'hC003, 16'h4000, 16'h0000);
    a0 = ack_cnt;
    pulse(1'b1, 1'b0, 22'h001000);
    wait_done("chain_done", 2000);
    chk("chain_err", {30'd0, err}, 32'd2);
    chk("chain_valid", {31'd0, valid}, 32'd0);
    chk("chain_desc", {10'd0, desc_adr}, 32'h00034000);
    chk("chain_dma_cycles", ack_cnt - a0, 32'd20);
    chk_queues("chain");
`endif

    // Status write-back after a fetch at 001000
    lat_cfg = 2;
    load_desc(22'h001000, 16'h8000, 16'h2000, 16'hFF00);
    push_fetch(22'h001000, 16'h8000, 16'h2000, 16'hFF00);
    pulse(1'b1, 1'b0, 22'h001000);
    wait_done("stat_prefetch_done", 300);
    preset4 = 16'h1234;
    preset5 = 16'h5678;
    exp_host.push_back({22'h001008, 16'h1234});
    exp_host.push_back({22'h00100A, 16'h5678});
    @(negedge clk);
    pulse(1'b0, 1'b1, 22'h000000);
    wait_done("stat_done", 300);
    chk("stat_host4", {16'd0, rd_host(22'h001008)}, 32'h00001234);
    chk("stat_host5", {16'd0, rd_host(22'h00100A)}, 32'h00005678);
    chk("stat_err", {30'd0, err}, 32'd0);
    chk("stat_desc", {10'd0, desc_adr}, 32'h00001000);
    chk_queues("stat");

    // Fetch and stat together: only the fetch runs
    @(negedge clk);
    load_desc(22'h005000, 16'h0000, 16'h0000, 16'h0000);
    push_fetch(22'h005000, 16'h0000, 16'h0000, 16'h0000);
    a0 = ack_cnt;
    pulse(1'b1, 1'b1, 22'h005000);
    wait_done("both_done", 300);
    repeat (10) @(negedge clk);
    chk("both_desc", {10'd0, desc_adr}, 32'h00005000);
    chk("both_dma_cycles", ack_cnt - a0, 32'd4);
    chk_queues("both");

    // Fetch while busy is ignored
    load_desc(22'h001000, 16'h8000, 16'h2000, 16'hFF00);
    load_desc(22'h006000, 16'h8000, 16'h0000, 16'h0000);
    push_fetch(22'h001000, 16'h8000, 16'h2000, 16'hFF00);
    pulse(1'b1, 1'b0, 22'h001000);
    repeat (3) @(negedge clk);
    pulse(1'b1, 1'b0, 22'h006000);
    wait_done("busy_done", 300);
    chk("busy_desc", {10'd0, desc_adr}, 32'h00001000);
    repeat (10) @(negedge clk);
    #1;
    chk("busy_no_rerun", {31'd0, busy}, 32'd0);
    chk_queues("busy");

    // Timeout: never ack
    ack_en = 1'b0;
    @(negedge clk);
    pulse(1'b1, 1'b0, 22'h007000);
    n = 0;
    for (int i = 0; i < 20 && !dma_req; i++) @(negedge clk);
    while (dma_req && n < 400) begin
      n++;
      @(negedge clk);
    end
    #1;
    chk("tmo_req_cycles", n, 32'd255);
    chk("tmo_done", {31'd0, done}, 32'd1);
    chk("tmo_err", {30'd0, err}, 32'd1);
    chk("tmo_valid", {31'd0, valid}, 32'd0);
    ack_en = 1'b1;
    repeat (3) @(negedge clk);
    chk_queues("tmo");

    // Reset asserted while RD2 is outstanding
    lat_cfg = 4;
    load_desc(22'h008000, 16'h8000, 16'h0001, 16'h0002);
    push_fetch(22'h008000, 16'h8000, 16'h0001, 16'h0002);
    a0 = ack_cnt;
    pulse(1'b1, 1'b0, 22'h008000);
    n = 0;
    while (!((ack_cnt - a0 == 2) && dma_req) && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("rst_reached_rd2", {31'd0, dma_req}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({busy, done, valid, err, desc_adr, dma_req, dma_we, dma_adr, dma_dat_o,
         bdl_stb, bdl_we, bdl_adr, bdl_dat_o} !== 88'd0) begin
      n_err++;
      $display("FAIL rst_outputs: got req %b busy %b desc %h dma_adr %h bdl_dat %h, required all 0",
               dma_req, busy, desc_adr, dma_adr, bdl_dat_o);
    end
    exp_host.delete();
    exp_bdl.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (done) n++;
    end
    chk("rst_no_done", n, 32'd0);
    chk("rst_idle", {30'd0, busy, dma_req}, 32'd0);
    chk_queues("rst");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, required finish");
    $fatal(1);
  end

endmodule
